// File: rtl/mu0_pkg.sv
// Shared MU0 memory-arbiter definitions: bus widths, arbiter states and master indices.
package mu0_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic logic [1:0] master_onehot(input logic idx);
    return (idx == M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mu0_rr_pick.sv
// Combinational two-way round-robin pick: a lone requester wins, a tie goes to
// the master that did not win last time.
module mu0_rr_pick
  import mu0_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner,
  output logic       valid
);

  // Winner selection from the request pair and the previous owner
  always_comb begin
    winner = M0;
    valid  = 1'b0;
    case (req)
      2'b01: begin
        winner = M0;
        valid  = 1'b1;
      end
      2'b10: begin
        winner = M1;
        valid  = 1'b1;
      end
      2'b11: begin
        winner = ~last_grant;
        valid  = 1'b1;
      end
      default: begin
        winner = M0;
        valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mu0_mem_arbiter.sv
// Two-master round-robin arbiter for the MU0 4K x 16 memory port.
// Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE (ack) -> IDLE.
module mu0_mem_arbiter
  import mu0_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              busy,
  output logic [1:0]        grant
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("mu0_mem_arbiter: WAIT_STATES must be in 0..15");
  end

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  arb_state_t        state_r;
  arb_state_t        state_s;
  logic              last_grant_r;
  logic              winner_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        count_r;
  logic [DATA_W-1:0] m0_rdata_r;
  logic [DATA_W-1:0] m1_rdata_r;
  logic              pick_winner_s;
  logic              pick_valid_s;

  mu0_rr_pick u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_r),
    .winner     (pick_winner_s),
    .valid      (pick_valid_s)
  );

  // Next-state decode; requests are only looked at while idle
  always_comb begin
    state_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) state_s = ARB_ACCESS;
        else              state_s = ARB_IDLE;
      end
      ARB_ACCESS: begin
        if (count_r == 4'd0) state_s = ARB_DONE;
        else                 state_s = ARB_ACCESS;
      end
      ARB_DONE: state_s = ARB_IDLE;
      default:  state_s = ARB_IDLE;
    endcase
  end

  // State, request latch, wait counter and per-master read-data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= M1;
      winner_r     <= M0;
      we_r         <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      count_r      <= 4'd0;
      m0_rdata_r   <= '0;
      m1_rdata_r   <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        ARB_IDLE: begin
          if (pick_valid_s) begin
            // last_grant tracks every grant so a tie always favours the other master
            winner_r     <= pick_winner_s;
            last_grant_r <= pick_winner_s;
            we_r         <= (pick_winner_s == M1) ? m1_we    : m0_we;
            addr_r       <= (pick_winner_s == M1) ? m1_addr  : m0_addr;
            wdata_r      <= (pick_winner_s == M1) ? m1_wdata : m0_wdata;
            count_r      <= WAIT_CNT;
          end
        end
        ARB_ACCESS: begin
          if (count_r != 4'd0) begin
            count_r <= count_r - 4'd1;
          end else if (!we_r) begin
            if (winner_r == M1) m1_rdata_r <= mem_rdata;
            else                m0_rdata_r <= mem_rdata;
          end
        end
        ARB_DONE: count_r <= 4'd0;
        default:  count_r <= 4'd0;
      endcase
    end
  end

  // Outputs decode only registered state, so reset removes the strobes at once
  always_comb begin
    busy      = (state_r != ARB_IDLE);
    grant     = (state_r != ARB_IDLE) ? master_onehot(winner_r) : 2'b00;
    mem_rd    = (state_r == ARB_ACCESS) && !we_r;
    mem_wr    = (state_r == ARB_ACCESS) && we_r;
    mem_addr  = addr_r;
    mem_wdata = wdata_r;
    m0_ack    = (state_r == ARB_DONE) && (winner_r == M0);
    m1_ack    = (state_r == ARB_DONE) && (winner_r == M1);
    m0_rdata  = m0_rdata_r;
    m1_rdata  = m1_rdata_r;
  end

endmodule

// File: tb/tb_mu0_mem_arbiter.sv
// Bench for mu0_mem_arbiter: directed vectors and corner sequences plus a
// randomized run checked against a transaction-level reference model.
module tb_mu0_mem_arbiter;

  localparam int WS_A = 1;
  localparam int WS_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A (WAIT_STATES = 1)
  logic        a_m0_req, a_m0_we, a_m0_ack, a_m1_req, a_m1_we, a_m1_ack;
  logic [11:0] a_m0_addr, a_m1_addr, a_mem_addr;
  logic [15:0] a_m0_wdata, a_m0_rdata, a_m1_wdata, a_m1_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_mem_rd, a_mem_wr, a_busy;
  logic [1:0]  a_grant;

  // Instance B (WAIT_STATES = 0)
  logic        b_m0_req, b_m0_we, b_m0_ack, b_m1_req, b_m1_we, b_m1_ack;
  logic [11:0] b_m0_addr, b_m1_addr, b_mem_addr;
  logic [15:0] b_m0_wdata, b_m0_rdata, b_m1_wdata, b_m1_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_mem_rd, b_mem_wr, b_busy;
  logic [1:0]  b_grant;

  mu0_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .busy(a_busy), .grant(a_grant)
  );

  mu0_mem_arbiter #(.ADDR_W(12), .DATA_W(16), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .busy(b_busy), .grant(b_grant)
  );

  // Power-up memory contents: a fixed pattern with 0x1234 at word 0x005
  function automatic logic [15:0] init_val(input logic [11:0] ad);
    return (ad == 12'h005) ? 16'h1234 : (16'hA5A5 ^ {4'h0, ad});
  endfunction

  bit          a_wv [4096];
  logic [15:0] a_wd [4096];
  bit          b_wv [4096];
  logic [15:0] b_wd [4096];

  always @(posedge clk) begin
    if (a_mem_wr) begin
      a_wv[a_mem_addr] <= 1'b1;
      a_wd[a_mem_addr] <= a_mem_wdata;
    end
    if (b_mem_wr) begin
      b_wv[b_mem_addr] <= 1'b1;
      b_wd[b_mem_addr] <= b_mem_wdata;
    end
  end

  assign a_mem_rdata = a_wv[a_mem_addr] ? a_wd[a_mem_addr] : init_val(a_mem_addr);
  assign b_mem_rdata = b_wv[b_mem_addr] ? b_wd[b_mem_addr] : init_val(b_mem_addr);

  function automatic logic [15:0] peek_a(input logic [11:0] ad);
    return a_wv[ad] ? a_wd[ad] : init_val(ad);
  endfunction

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_m0_req = 1'b0; a_m0_we = 1'b0; a_m0_addr = 12'h000; a_m0_wdata = 16'h0000;
    a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = 12'h000; a_m1_wdata = 16'h0000;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = 12'h000; b_m0_wdata = 16'h0000;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = 12'h000; b_m1_wdata = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic        mst;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_m0_rdata;
    logic [15:0] exp_m1_rdata;
  } vec_t;

  vec_t vecs [7];

  // One access on instance A: checks ack latency, read data on both masters and write commit
  task automatic run_vec(input vec_t v);
    int  n;
    bit  got;
    tick();
    if (v.mst) begin
      a_m1_req = 1'b1; a_m1_we = v.we; a_m1_addr = v.addr; a_m1_wdata = v.wdata;
    end else begin
      a_m0_req = 1'b1; a_m0_we = v.we; a_m0_addr = v.addr; a_m0_wdata = v.wdata;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = v.mst ? a_m1_ack : a_m0_ack;
    end
    chk("tbl_ack_seen", 32'(got), 32'(1'b1));
    chk("tbl_latency", 32'(n), 32'(WS_A + 2));
    chk("tbl_other_ack", 32'(v.mst ? a_m0_ack : a_m1_ack), 32'(1'b0));
    chk("tbl_m0_rdata", 32'(a_m0_rdata), 32'(v.exp_m0_rdata));
    chk("tbl_m1_rdata", 32'(a_m1_rdata), 32'(v.exp_m1_rdata));
    a_m0_req = 1'b0;
    a_m1_req = 1'b0;
    if (v.we) chk("tbl_mem_write", 32'(peek_a(v.addr)), 32'(v.wdata));
  endtask

  // Reference model state for the randomized run
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_read(input logic [11:0] ad);
    return ref_mem.exists(int'(ad)) ? ref_mem[int'(ad)] : init_val(ad);
  endfunction

  initial begin
    int          n_ack, overl, bad_order, bad_gap, gbad, prev;
    bit          ack_seen;
    int          e, next_free, ack_edge;
    logic        last, w, exp_mst, exp_we;
    logic [11:0] ad;
    logic [15:0] exp_val, r0, r1;

    vecs[0] = '{1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 12'h0FF, 16'hBEEF, 16'h1234, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 12'h0FF, 16'h0000, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 12'h005, 16'h0000, 16'hBEEF, 16'h1234};
    vecs[4] = '{1'b0, 1'b1, 12'hFFF, 16'hFFFF, 16'hBEEF, 16'h1234};
    vecs[5] = '{1'b1, 1'b0, 12'hFFF, 16'h0000, 16'hBEEF, 16'hFFFF};
    vecs[6] = '{1'b0, 1'b0, 12'h000, 16'h0000, 16'hA5A5, 16'hFFFF};

    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(a_busy), 32'(1'b0));
    chk("rst_grant", 32'(a_grant), 32'(2'b00));
    chk("rst_strobes", 32'({a_mem_rd, a_mem_wr}), 32'(2'b00));
    chk("rst_acks", 32'({a_m0_ack, a_m1_ack}), 32'(2'b00));
    chk("rst_rdata", 32'({a_m0_rdata, a_m1_rdata}), 32'h0);
    chk("rst_mem_addr", 32'(a_mem_addr), 32'h0);

    // Reset asserted in the middle of an M0 write
    do_reset();
    tick();
    a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 12'h010; a_m0_wdata = 16'h5555;
    tick();
    chk("t1_wr_on", 32'(a_mem_wr), 32'(1'b1));
    #2;
    rst = 1'b0;
    a_m0_req = 1'b0;
    a_m0_we  = 1'b0;
    #1;
    chk("t1_wr_drop", 32'(a_mem_wr), 32'(1'b0));
    chk("t1_busy_in_rst", 32'(a_busy), 32'(1'b0));
    ack_seen = 1'b0;
    repeat (2) begin
      tick();
      if (a_m0_ack) ack_seen = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      tick();
      if (a_m0_ack) ack_seen = 1'b1;
    end
    chk("t1_no_ack", 32'(ack_seen), 32'(1'b0));
    chk("t1_busy_after", 32'(a_busy), 32'(1'b0));
    chk("t1_mem_unchanged", 32'(peek_a(12'h010)), 32'(init_val(12'h010)));

    // Directed single accesses
    do_reset();
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Both masters requesting continuously from reset
    rst = 1'b0;
    clear_inputs();
    a_m0_req = 1'b1; a_m0_addr = 12'h001;
    a_m1_req = 1'b1; a_m1_addr = 12'h002;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_ack = 0; overl = 0; bad_order = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (a_m0_ack && a_m1_ack) overl++;
      if (a_m0_ack || a_m1_ack) begin
        if (int'(a_m1_ack) != (n_ack % 2)) bad_order++;
        n_ack++;
      end
    end
    chk("t4_overlap", 32'(overl), 32'h0);
    chk("t4_order", 32'(bad_order), 32'h0);
    chk("t4_ack_count", 32'(n_ack), 32'd10);
    chk("t4_m0_rdata", 32'(a_m0_rdata), 32'(init_val(12'h001)));
    chk("t4_m1_rdata", 32'(a_m1_rdata), 32'(init_val(12'h002)));

    // M1 drops its request and scrambles its inputs during a write
    do_reset();
    tick();
    a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 12'h0A5; a_m1_wdata = 16'h00FF;
    tick();
    a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = 12'h0A6; a_m1_wdata = 16'h1111;
    n_ack = 0;
    repeat (8) begin
      tick();
      if (a_m1_ack) n_ack++;
    end
    chk("t6_ack_once", 32'(n_ack), 32'd1);
    chk("t6_mem_written", 32'(peek_a(12'h0A5)), 32'h00FF);
    chk("t6_mem_neighbour", 32'(peek_a(12'h0A6)), 32'(init_val(12'h0A6)));
    chk("t6_m1_rdata", 32'(a_m1_rdata), 32'h0);

    // Zero wait states, M0 alone holding its request on instance B
    rst = 1'b0;
    clear_inputs();
    b_m0_req = 1'b1; b_m0_addr = 12'h003;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_ack = 0; bad_gap = 0; gbad = 0; prev = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (b_busy ? (b_grant != 2'b01) : (b_grant != 2'b00)) gbad++;
      if (b_m0_ack) begin
        if (prev < 0 ? (i != 2) : (i - prev != 3)) bad_gap++;
        prev = i;
        n_ack++;
      end
    end
    chk("t5_grant", 32'(gbad), 32'h0);
    chk("t5_ack_spacing", 32'(bad_gap), 32'h0);
    chk("t5_ack_count", 32'(n_ack), 32'd10);
    chk("t5_m0_rdata", 32'(b_m0_rdata), 32'(init_val(12'h003)));

    // Randomized traffic on instance A against the transaction-level model
    do_reset();
    e = 0; next_free = 0; ack_edge = -1;
    last = 1'b1; exp_mst = 1'b0; exp_we = 1'b0; exp_val = 16'h0000;
    r0 = 16'h0000; r1 = 16'h0000;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      e++;
      if (e >= next_free && (a_m0_req || a_m1_req)) begin
        w        = (a_m0_req && a_m1_req) ? ~last : a_m1_req;
        last     = w;
        exp_mst  = w;
        exp_we   = w ? a_m1_we : a_m0_we;
        ad       = w ? a_m1_addr : a_m0_addr;
        ack_edge = e + WS_A + 1;
        next_free = e + WS_A + 3;
        if (exp_we) ref_mem[int'(ad)] = w ? a_m1_wdata : a_m0_wdata;
        else        exp_val = ref_read(ad);
      end
      #1;
      if (e == ack_edge && !exp_we) begin
        if (exp_mst) r1 = exp_val;
        else         r0 = exp_val;
      end
      chk("rnd_m0_ack", 32'(a_m0_ack), 32'(e == ack_edge && !exp_mst));
      chk("rnd_m1_ack", 32'(a_m1_ack), 32'(e == ack_edge && exp_mst));
      chk("rnd_busy", 32'(a_busy), 32'(e <= next_free - 2));
      chk("rnd_m0_rdata", 32'(a_m0_rdata), 32'(r0));
      chk("rnd_m1_rdata", 32'(a_m1_rdata), 32'(r1));
      if (a_m0_ack) a_m0_req = 1'b0;
      else if (!a_m0_req && $urandom_range(0, 2) == 0) begin
        a_m0_req   = 1'b1;
        a_m0_we    = 1'($urandom_range(0, 1));
        a_m0_addr  = 12'h200 + 12'($urandom_range(0, 15));
        a_m0_wdata = 16'($urandom);
      end
      if (a_m1_ack) a_m1_req = 1'b0;
      else if (!a_m1_req && $urandom_range(0, 2) == 0) begin
        a_m1_req   = 1'b1;
        a_m1_we    = 1'($urandom_range(0, 1));
        a_m1_addr  = 12'h200 + 12'($urandom_range(0, 15));
        a_m1_wdata = 16'($urandom);
      end
    end
    a_m0_req = 1'b0;
    a_m1_req = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 16; i++) begin
      ad = 12'h200 + 12'(i);
      chk("rnd_mem", 32'(peek_a(ad)), 32'(ref_read(ad)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
